uart1_tx: RTL and testbench

- Configurable UART transmit serializer.
- Captures an 8-bit byte and a frame configuration, then shifts out idle/start/data/parity/stop on a single serial line.
- Sits between a byte source (the stimulus/tester block) and the serial link.
- Line idles high; data goes LSB first.

---
 rtl/uart1_tx.sv | 192 +++++++++++++++++++
 tb/tb_uart1_tx.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart1_tx.sv
// uart1_tx - configurable UART transmit serializer.
//
// Captures a byte and its frame configuration when a request arrives in IDLE.
// It then shifts out start, data (LSB first), optional parity, stop and
// optional idle-gap bit periods on a registered serial line that idles high.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit period (>= 2)
//
// Ports:
//   clk         system clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   idle_bit    number of forced idle (high) bit periods after the stop bits, 0-3
//   start_bit   0 = no request, 1-3 = request a frame with that many start bits
//   tx1         data byte to send
//   parity_bit  00 none, 01 even, 10 odd, 11 forced 0
//   stop_bit    00/01 one stop bit, 10/11 two stop bits
//   serial_out  serial line, idles high
module uart1_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] idle_bit,
    input  logic [1:0] start_bit,
    input  logic [7:0] tx1,
    input  logic [1:0] parity_bit,
    input  logic [1:0] stop_bit,
    output logic       serial_out
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        GAP
    } state_t;

    state_t        state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    per_cnt;
    logic [7:0]    shift_reg;
    logic [1:0]    start_lat;
    logic [1:0]    parity_lat;
    logic [1:0]    stop_lat;
    logic [1:0]    idle_lat;
    logic          parity_val;

    logic          bit_end;
    logic [1:0]    stop_last;

    // bit_end marks the last clock of the current bit period.
    // stop_last is the index of the final stop-bit period.
    always_comb begin
        bit_end   = (clk_cnt == CW'(CLKS_PER_BIT - 1));
        stop_last = (stop_lat >= 2'd2) ? 2'd1 : 2'd0;
    end

    // Frame sequencer. serial_out is registered: each transition edge loads
    // the level of the bit period that begins on that edge. The parity bit
    // is computed at capture time because the shift register is consumed
    // while the data bits go out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            per_cnt    <= '0;
            shift_reg  <= '0;
            start_lat  <= '0;
            parity_lat <= '0;
            stop_lat   <= '0;
            idle_lat   <= '0;
            parity_val <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    clk_cnt    <= '0;
                    bit_idx    <= '0;
                    per_cnt    <= '0;
                    if (start_bit != 2'd0) begin
                        shift_reg  <= tx1;
                        start_lat  <= start_bit;
                        parity_lat <= parity_bit;
                        stop_lat   <= stop_bit;
                        idle_lat   <= idle_bit;
                        case (parity_bit)
                            2'b01:   parity_val <= ^tx1;
                            2'b10:   parity_val <= ~^tx1;
                            default: parity_val <= 1'b0;
                        endcase
                        serial_out <= 1'b0;
                        state      <= START;
                    end
                end

                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (per_cnt == start_lat - 2'd1) begin
                            per_cnt    <= '0;
                            serial_out <= shift_reg[0];
                            state      <= DATA;
                        end else begin
                            per_cnt <= per_cnt + 2'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (parity_lat != 2'b00) begin
                                serial_out <= parity_val;
                                state      <= PARITY;
                            end else begin
                                serial_out <= 1'b1;
                                state      <= STOP;
                            end
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            shift_reg  <= shift_reg >> 1;
                            serial_out <= shift_reg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                PARITY: begin
                    if (bit_end) begin
                        clk_cnt    <= '0;
                        serial_out <= 1'b1;
                        state      <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (per_cnt == stop_last) begin
                            per_cnt    <= '0;
                            serial_out <= 1'b1;
                            state      <= (idle_lat != 2'd0) ? GAP : IDLE;
                        end else begin
                            per_cnt <= per_cnt + 2'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                GAP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (per_cnt == idle_lat - 2'd1) begin
                            per_cnt    <= '0;
                            serial_out <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            per_cnt <= per_cnt + 2'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end

                default: begin
                    serial_out <= 1'b1;
                    clk_cnt    <= '0;
                    bit_idx    <= '0;
                    per_cnt    <= '0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart1_tx.sv
// tb_uart1_tx - self-checking bench for uart1_tx.
//
// A reference model turns every accepted request into the list of line
// levels the frame should produce, one entry per clock, and appends them to
// a queue. A separate monitor pops one entry per cycle and compares it with
// serial_out; with nothing queued the line must be high.
module tb_uart1_tx;

    localparam int CPB = 4;

    logic       clk;
    logic       rst;
    logic [1:0] idle_bit;
    logic [1:0] start_bit;
    logic [7:0] tx1;
    logic [1:0] parity_bit;
    logic [1:0] stop_bit;
    logic       serial_out;

    int checks = 0;
    int errors = 0;

    bit exp_q[$];
    bit prev_empty = 1'b1;
    bit mon_en = 1'b0;

    uart1_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .idle_bit   (idle_bit),
        .start_bit  (start_bit),
        .tx1        (tx1),
        .parity_bit (parity_bit),
        .stop_bit   (stop_bit),
        .serial_out (serial_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record one comparison and report it if it does not hold.
    function automatic void checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endfunction

    // Build the frame from its definition: S start lows, 8 data bits LSB
    // first, optional parity, 1 or 2 stop highs, G gap highs, each bit
    // lasting CPB clocks.
    function automatic void pushFrame(input logic [7:0] d, input logic [1:0] s,
                                      input logic [1:0] p, input logic [1:0] t,
                                      input logic [1:0] g);
        bit lv[$];
        for (int i = 0; i < int'(s); i++) lv.push_back(1'b0);
        for (int i = 0; i < 8; i++) lv.push_back(d[i]);
        if (p == 2'b01) lv.push_back(^d);
        else if (p == 2'b10) lv.push_back(~^d);
        else if (p == 2'b11) lv.push_back(1'b0);
        for (int i = 0; i < ((t >= 2'd2) ? 2 : 1); i++) lv.push_back(1'b1);
        for (int i = 0; i < int'(g); i++) lv.push_back(1'b1);
        foreach (lv[k])
            for (int c = 0; c < CPB; c++) exp_q.push_back(lv[k]);
    endfunction

    // Reference model: a request is taken only when the line has been
    // quiet for a full clock after the previous frame finished.
    always @(posedge clk) begin
        if (!rst) begin
            exp_q.delete();
            prev_empty = 1'b1;
        end else begin
            if (exp_q.size() == 0 && prev_empty && start_bit != 2'd0)
                pushFrame(tx1, start_bit, parity_bit, stop_bit, idle_bit);
            prev_empty = (exp_q.size() == 0);
        end
    end

    // Monitor: one comparison per clock, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit e;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
            checkOutput("serial_out", serial_out, e);
        end
    end

    task automatic applyStimulus(input logic [1:0] s, input logic [7:0] d,
                                 input logic [1:0] p, input logic [1:0] t,
                                 input logic [1:0] g);
        start_bit  = s;
        tx1        = d;
        parity_bit = p;
        stop_bit   = t;
        idle_bit   = g;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One-cycle request followed by enough quiet time for the frame.
    task automatic sendFrame(input logic [1:0] s, input logic [7:0] d,
                             input logic [1:0] p, input logic [1:0] t,
                             input logic [1:0] g);
        applyStimulus(s, d, p, t, g);
        waitCycles(1);
        start_bit = 2'd0;
        waitCycles(75);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(2'd0, 8'h00, 2'd0, 2'd0, 2'd0);
        #2 rst = 1'b0;
        waitCycles(2);
        checkOutput("reset_state", serial_out, 1'b1);
        mon_en = 1'b1;
        rst = 1'b1;
        waitCycles(3);

        $display("[TB] basic 8N1 and parity modes");
        sendFrame(2'd1, 8'hA5, 2'b00, 2'b01, 2'd0);
        sendFrame(2'd1, 8'hA5, 2'b01, 2'b01, 2'd0);
        sendFrame(2'd1, 8'hA5, 2'b10, 2'b01, 2'd0);
        sendFrame(2'd1, 8'hA5, 2'b11, 2'b01, 2'd0);
        sendFrame(2'd1, 8'h07, 2'b01, 2'b00, 2'd0);

        $display("[TB] multi start/stop with gap");
        sendFrame(2'd2, 8'h00, 2'b00, 2'b10, 2'd3);

        $display("[TB] inputs changed mid-frame");
        applyStimulus(2'd1, 8'hA5, 2'b01, 2'b01, 2'd0);
        waitCycles(1);
        start_bit = 2'd0;
        waitCycles(5);
        applyStimulus(2'd0, 8'hFF, 2'b10, 2'b11, 2'd3);
        waitCycles(50);

        $display("[TB] back-to-back frames");
        applyStimulus(2'd1, 8'h55, 2'b00, 2'b01, 2'd0);
        waitCycles(130);
        start_bit = 2'd0;
        waitCycles(45);

        $display("[TB] reset during data");
        applyStimulus(2'd1, 8'hA5, 2'b00, 2'b01, 2'd0);
        waitCycles(1);
        start_bit = 2'd0;
        waitCycles(8);
        rst = 1'b0;
        #1;
        checkOutput("reset_async", serial_out, 1'b1);
        exp_q.delete();
        waitCycles(3);
        rst = 1'b1;
        waitCycles(12);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 1500; n++) begin
            applyStimulus(($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                          8'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            waitCycles(1);
        end

        start_bit = 2'd0;
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) waitCycles(1);
        waitCycles(3);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d expected levels left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
